// File: rtl/adder_err_pkg.sv
// Shared widths, FSM states and bit helpers for the approximate-adder error monitor.
package adder_err_pkg;
    localparam int OP_W   = 4;
    localparam int RES_W  = 5;
    localparam int PI_W   = 9;
    localparam int STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // po carries the result LSB-last: value bit j lives at po[4-j]
    function automatic logic [RES_W-1:0] bitrev5(input logic [RES_W-1:0] po);
        logic [RES_W-1:0] v;
        for (int i = 0; i < RES_W; i++) v[i] = po[RES_W-1-i];
        return v;
    endfunction

    function automatic logic [2:0] popcount5(input logic [RES_W-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < RES_W; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/adder_err_calc.sv
// Two-stage pipeline: exact sum / reordered approx, then error distance and Hamming distance.
module adder_err_calc
    import adder_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [PI_W-1:0]   i_pi,
    input  logic [RES_W-1:0]  i_po,
    output logic [STAGES:1]   o_vld_pipe,
    output logic [RES_W-1:0]  o_ed,
    output logic [2:0]        o_hd
);
    logic [STAGES:1]     r_vld_pipe;
    logic [RES_W-1:0]    r_exact, r_approx, r_ed;
    logic [2:0]          r_hd;
    logic [RES_W-1:0]    w_exact, w_mag;
    logic signed [RES_W:0] w_diff, w_neg;

    assign w_exact = RES_W'(i_pi[OP_W-1:0]) + RES_W'(i_pi[2*OP_W-1:OP_W]) + RES_W'(i_pi[PI_W-1]);
    assign w_diff  = $signed({1'b0, r_approx}) - $signed({1'b0, r_exact});
    assign w_neg   = -w_diff;
    assign w_mag   = w_diff[RES_W] ? w_neg[RES_W-1:0] : w_diff[RES_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_exact    <= '0;
            r_approx   <= '0;
            r_ed       <= '0;
            r_hd       <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_vld};
            r_exact    <= w_exact;
            r_approx   <= bitrev5(i_po);
            r_ed       <= w_mag;
            r_hd       <= popcount5(r_approx ^ r_exact);
        end
    end

    assign o_vld_pipe = r_vld_pipe;
    assign o_ed       = r_ed;
    assign o_hd       = r_hd;
endmodule

// File: rtl/adder_err_monitor.sv
// Windowed error characterisation of an approximate adder: FSM, handshake and saturating metrics.
module adder_err_monitor
    import adder_err_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PI_W-1:0]   pi,
    input  logic [RES_W-1:0]  po,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [RES_W-1:0]  max_ed,
    output logic [ACC_W-1:0]  bit_err
);
    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_n, r_acc_cnt, r_err_cnt;
    logic [ACC_W-1:0]   r_sum_ed, r_bit_err;
    logic [RES_W-1:0]   r_max_ed;
    logic               w_accept, w_last, w_start_ok;
    logic [STAGES:1]    w_vld_pipe;
    logic [RES_W-1:0]   w_ed;
    logic [2:0]         w_hd;
    logic [ACC_W:0]     w_sum_ext, w_bit_ext;

    assign in_ready   = (r_state == RUN);
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_acc_cnt + CNT_W'(1)) == r_n;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    adder_err_calc u_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vld      (w_accept),
        .i_pi       (pi),
        .i_po       (po),
        .o_vld_pipe (w_vld_pipe),
        .o_ed       (w_ed),
        .o_hd       (w_hd)
    );

    // A zero-length window skips RUN so in_ready never rises
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = (n_samples == '0) ? DONE : RUN;
            RUN:        if (w_accept && w_last) w_state_nxt = DRAIN;
            DRAIN:      if (w_vld_pipe == '0) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    assign w_sum_ext = {1'b0, r_sum_ed}  + {{(ACC_W+1-RES_W){1'b0}}, w_ed};
    assign w_bit_ext = {1'b0, r_bit_err} + {{(ACC_W-2){1'b0}}, w_hd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_acc_cnt <= '0;
            r_err_cnt <= '0;
            r_sum_ed  <= '0;
            r_bit_err <= '0;
            r_max_ed  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_n       <= n_samples;
                r_acc_cnt <= '0;
                r_err_cnt <= '0;
                r_sum_ed  <= '0;
                r_bit_err <= '0;
                r_max_ed  <= '0;
            end else begin
                if (w_accept) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                if (w_vld_pipe[STAGES]) begin
                    if (w_ed != '0) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    r_sum_ed  <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
                    r_bit_err <= w_bit_ext[ACC_W] ? '1 : w_bit_ext[ACC_W-1:0];
                    if (w_ed > r_max_ed) r_max_ed <= w_ed;
                end
            end
        end
    end

    assign err_cnt = r_err_cnt;
    assign sum_ed  = r_sum_ed;
    assign max_ed  = r_max_ed;
    assign bit_err = r_bit_err;
endmodule

// File: tb/tb_adder_err_monitor.sv
// Directed bench for adder_err_monitor: vector table of windows plus hand-written corner sequences.
module tb_adder_err_monitor;
    localparam int CNT_W = 16;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst_n, start, in_valid, in_ready, busy, done;
    logic [CNT_W-1:0] n_samples, err_cnt;
    logic [8:0]       pi;
    logic [4:0]       po, max_ed;
    logic [ACC_W-1:0] sum_ed, bit_err;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .pi(pi), .po(po),
        .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .bit_err(bit_err)
    );

    typedef struct {
        string          name;
        int             n;
        bit             gap;
        logic [3:0][8:0] vpi;
        logic [3:0][4:0] vpo;
        int             ec, se, me, be;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        n_samples = CNT_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [8:0] p, input logic [4:0] q);
        int t = 0;
        in_valid = 1'b1;
        pi = p;
        po = q;
        while (!in_ready && t < 10) begin
            step();
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 20) begin
            step();
            t++;
        end
        check({nm, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int hs;
        // value bit j is carried on po[4-j]
        tbl[0] = '{"exact", 4, 1'b0, {9'h101, 9'h053, 9'h1FF, 9'h000},
                   {5'b01000, 5'b00010, 5'b11111, 5'b00000}, 0, 0, 0, 0};
        tbl[1] = '{"single", 1, 1'b0, {9'h0, 9'h0, 9'h0, 9'h011},
                   {5'b0, 5'b0, 5'b0, 5'b00100}, 1, 2, 2, 2};
        tbl[2] = '{"under", 2, 1'b0, {9'h0, 9'h0, 9'h011, 9'h1FF},
                   {5'b0, 5'b0, 5'b11000, 5'b00000}, 2, 32, 31, 6};
        tbl[3] = '{"mixed_gap", 3, 1'b1, {9'h0, 9'h022, 9'h0FF, 9'h000},
                   {5'b0, 5'b00000, 5'b01111, 5'b10000}, 2, 5, 4, 2};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; n_samples = '0; pi = '0; po = '0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_sum_ed", 32'(sum_ed), 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            do_start(tbl[v].n);
            check({tbl[v].name, "_busy"}, 32'(busy), 1);
            for (int i = 0; i < tbl[v].n; i++) begin
                send(tbl[v].vpi[i], tbl[v].vpo[i]);
                if (tbl[v].gap) step();
            end
            wait_done(tbl[v].name);
            check({tbl[v].name, "_err_cnt"}, 32'(err_cnt), 32'(tbl[v].ec));
            check({tbl[v].name, "_sum_ed"},  32'(sum_ed),  32'(tbl[v].se));
            check({tbl[v].name, "_max_ed"},  32'(max_ed),  32'(tbl[v].me));
            check({tbl[v].name, "_bit_err"}, 32'(bit_err), 32'(tbl[v].be));
        end

        // window limit: valid held for 6 cycles, only 3 taken
        do_start(3);
        in_valid = 1'b1; pi = 9'h1FF; po = 5'b00000;
        hs = 0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("lim_ready_c%0d", k), 32'(in_ready), 32'(k <= 3));
            if (in_valid && in_ready) hs++;
            step();
            check($sformatf("lim_done_c%0d", k), 32'(done), 32'(k == 6));
        end
        in_valid = 1'b0;
        check("lim_handshakes", 32'(hs), 3);
        check("lim_err_cnt", 32'(err_cnt), 3);
        check("lim_sum_ed", 32'(sum_ed), 93);

        // zero-length window
        check("zero_pre_ready", 32'(in_ready), 0);
        do_start(0);
        check("zero_done", 32'(done), 1);
        check("zero_ready", 32'(in_ready), 0);
        check("zero_err_cnt", 32'(err_cnt), 0);
        check("zero_sum_ed", 32'(sum_ed), 0);

        // start during RUN must not relatch or clear
        do_start(2);
        in_valid = 1'b1; pi = 9'h011; po = 5'b00100;
        start = 1'b1; n_samples = 16'd5;
        step();
        start = 1'b0; in_valid = 1'b0;
        send(9'h000, 5'b00000);
        check("ign_ready_after_2", 32'(in_ready), 0);
        wait_done("ign");
        check("ign_err_cnt", 32'(err_cnt), 1);
        check("ign_sum_ed", 32'(sum_ed), 2);

        // reset mid-window
        do_start(5);
        send(9'h1FF, 5'b00000);
        send(9'h1FF, 5'b00000);
        step();
        step();
        check("mid_pre_err_cnt", 32'(err_cnt), 2);
        rst_n = 1'b0;
        #1;
        check("mid_err_cnt", 32'(err_cnt), 0);
        check("mid_sum_ed", 32'(sum_ed), 0);
        check("mid_max_ed", 32'(max_ed), 0);
        check("mid_bit_err", 32'(bit_err), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_ready", 32'(in_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        do_start(1);
        send(9'h011, 5'b00100);
        wait_done("post_rst");
        check("post_rst_err_cnt", 32'(err_cnt), 1);
        check("post_rst_sum_ed", 32'(sum_ed), 2);
        check("post_rst_bit_err", 32'(bit_err), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder_err_monitor.md
Name: adder_err_monitor

Overview:
- Streaming error-characterisation stage downstream of the 9-input/5-output approximate adder netlists.
- Per sample it consumes the adder inputs and the approximate outputs, recomputes the exact sum, and accumulates four error metrics over a programmed window: mismatch count, summed error distance, maximum error distance and bit-flip count.
- Results are held for readout by the characterisation harness until the next start.

Parameters:
- CNT_W, 16, width of the sample counter, n_samples and err_cnt.
- ACC_W, 24, width of the sum_ed and bit_err accumulators (saturating).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; clears all metrics and opens a window.
- n_samples  input  CNT_W  window length; sampled on the start cycle.
- in_valid  input  1  pi/po carry a sample.
- in_ready  output  1  monitor accepts a sample this cycle.
- pi  input  9  adder inputs: a[3:0]=pi[3:0], b[3:0]=pi[7:4], cin=pi[8].
- po  input  5  approximate result: bit j of the value = po[4-j], so po[4] is the LSB and po[0] the carry-out.
- busy  output  1  window open or pipeline not drained.
- done  output  1  level; metrics are final.
- err_cnt  output  CNT_W  samples with approx != exact.
- sum_ed  output  ACC_W  sum of |approx - exact|.
- max_ed  output  5  maximum |approx - exact|.
- bit_err  output  ACC_W  sum of popcount(approx XOR exact).

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all counters, accumulators and pipeline valids = 0.
  - in_ready=0, busy=0, done=0.
- States:
  - IDLE: waits for start.
  - RUN: accepts samples.
  - DRAIN: waits for the pipeline to empty.
  - DONE: results valid.
- Transitions:
  - IDLE or DONE + start -> RUN. On that cycle clear metrics and the accepted count, and latch n_samples.
  - If the latched n_samples = 0, go directly to DONE on the next cycle with all metrics 0.
  - RUN: in_ready=1. A sample is accepted when in_valid & in_ready.
  - RUN -> DRAIN on the cycle the n_samples-th sample is accepted. in_ready drops the following cycle; no sample beyond n_samples is ever accepted.
  - DRAIN -> DONE when both pipeline stage valids are 0.
  - DONE holds until start.
- start during RUN or DRAIN is ignored; there is no abort apart from rst_n.
- busy=1 in RUN and DRAIN. done=1 only in DONE.
- Pipeline (latency 2 from accept to metrics update):
  - S1 registers exact = a + b + cin (5 bits, unsigned) and approx = bit-reversed po.
  - S2 registers ed = |approx - exact| (5 bits, computed as the 6-bit signed difference, magnitude) and hd = popcount(approx XOR exact) (3 bits).
  - Accumulate stage on S2 valid:
    - err_cnt += (ed != 0).
    - sum_ed += ed.
    - bit_err += hd.
    - max_ed = max(max_ed, ed).
- Saturation: sum_ed and bit_err saturate at all-ones. err_cnt cannot overflow because it is bounded by n_samples.
- Metrics outputs are live registers: valid to read at any time, final only when done=1.
- Back-to-back samples at 1 per cycle are fully supported, and gaps in in_valid are allowed. The pipeline advances unconditionally, with no stall and no output backpressure.
- Reset mid-window: everything returns to reset values immediately and samples in flight are discarded.

Decomposition:
- Shared package adder_err_pkg:
  - widths: OP_W=4, RES_W=5, PI_W=9.
  - state enum: IDLE, RUN, DRAIN, DONE.
  - function bitrev5 (po to value).
  - function popcount5.
- One sub-module, adder_err_calc: the 2-stage exact-sum / error-distance / Hamming pipeline with valid pass-through.
- FSM and accumulators stay in the top.

Test Plan:
- Exact match: start, n_samples=4. Send pi=0x000/po=5'b00000, pi=0x1FF/po=5'b11111 (31 reverses to 31; exact 15+15+1=31), and two more exact samples. Required: done after the 4 samples plus drain; err_cnt=0, sum_ed=0, max_ed=0, bit_err=0.
- Single error: n_samples=1. Send pi=9'b0_0001_0001 (a=1, b=1, cin=0, exact 2) with po=5'b00100 (approx 4). Required: err_cnt=1, sum_ed=2, max_ed=2, bit_err=2.
- Underestimate and max tracking: n_samples=2.
  - Sample 1: a=15, b=15, cin=1 (exact 31) with approx 0. Gives ed=31, hd=5.
  - Sample 2: exact 2 with approx 3. Gives ed=1, hd=1.
  - Required: err_cnt=2, sum_ed=32, max_ed=31, bit_err=6.
- Window limit: n_samples=3, in_valid held high for 6 cycles. Required: exactly 3 handshakes, in_ready low from the 4th cycle on, done asserted at the 3rd accept + 3 cycles.
- Zero window and start-ignore:
  - start with n_samples=0: done=1 the next cycle, with in_ready never high.
  - start pulsed again during RUN: no effect on the count.
- Reset mid-window: assert rst_n=0 after 2 of 5 samples. Required: all outputs 0 immediately; a fresh start with n_samples=1 then behaves normally.
